// File: rtl/cpu_step_ctrl.sv
// Run / single-step / halt control for the RISC-V core clock enable.
// Turns the divided sclk square wave into one-cycle cpu_en pulses on clk.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             sw_run,
  input  logic             btn_step,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic [1:0]       run_state,
  output logic             halted,
  output logic [CNT_W-1:0] en_cnt
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STOP = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t state;

  logic s1, s2, s3;
  logic r1, r2;
  logic b1, b2;
  logic [DW-1:0] db_cnt;
  logic db, db_d;
  logic tick, step_req, fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      r1 <= 1'b0;
      r2 <= 1'b0;
      b1 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      s1 <= sclk;
      s2 <= s1;
      s3 <= s2;
      r1 <= sw_run;
      r2 <= r1;
      b1 <= btn_step;
      b2 <= b1;
    end
  end

  assign tick = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db     <= 1'b0;
      db_d   <= 1'b0;
    end else begin
      db_d <= db;
      if (b2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= ~db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign step_req = db & ~db_d;

  // halt_in wins over a coincident tick in both pulsing states
  assign fire = tick & ~halt_in &
                (((state == RUN) & r2) | (state == STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STOP;
      cpu_en <= 1'b0;
      en_cnt <= '0;
    end else begin
      cpu_en <= fire;
      if (fire && en_cnt != '1)
        en_cnt <= en_cnt + CNT_W'(1);
      unique case (state)
        STOP: begin
          if (r2)
            state <= RUN;
          else if (step_req)
            state <= STEP;
        end
        RUN: begin
          if (halt_in)
            state <= HALT;
          else if (!r2)
            state <= STOP;
        end
        STEP: begin
          if (halt_in)
            state <= HALT;
          else if (tick)
            state <= STOP;
        end
        HALT: begin
          if (!r2)
            state <= STOP;
        end
        default: state <= STOP;
      endcase
    end
  end

  assign run_state = state;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: run, step, halt, saturation, reset.
// DEBOUNCE_CYCLES=4, CNT_W=4, sclk period = 20 clk.
module tb_cpu_step_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       sw_run;
  logic       btn_step;
  logic       halt_in;
  logic       cpu_en;
  logic [1:0] run_state;
  logic       halted;
  logic [3:0] en_cnt;

  int n_cmp  = 0;
  int n_err  = 0;
  int npulse = 0;
  int nwide  = 0;
  int n0;
  bit en_prev = 1'b0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .sw_run(sw_run),
    .btn_step(btn_step),
    .halt_in(halt_in),
    .cpu_en(cpu_en),
    .run_state(run_state),
    .halted(halted),
    .en_cnt(en_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    sclk = 1'b0;
    #3;
    forever #100 sclk = ~sclk;
  end

  always @(negedge clk) begin
    if (cpu_en) npulse++;
    if (cpu_en && en_prev) nwide++;
    en_prev = cpu_en;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 1);
  endtask

  initial begin
    rst_n    = 1'b1;
    sw_run   = 1'b0;
    btn_step = 1'b0;
    halt_in  = 1'b0;
    #2 rst_n = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst_en", 32'(cpu_en), 0);
    chk("rst_st", 32'(run_state), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cnt", 32'(en_cnt), 0);

    // 1: free run for 5 sclk periods, latency N+2
    @(negedge sclk);
    rst_n  = 1'b1;
    sw_run = 1'b1;
    repeat (4) @(posedge sclk);
    @(posedge sclk);
    @(posedge clk);
    @(negedge clk);
    chk("lat0", 32'(cpu_en), 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat1", 32'(cpu_en), 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat2", 32'(cpu_en), 1);
    @(posedge clk);
    @(negedge clk);
    chk("lat3", 32'(cpu_en), 0);
    chk("run_cnt", 32'(en_cnt), 5);
    chk("run_st", 32'(run_state), 1);
    chk("run_pulses", 32'(npulse), 5);

    // 2: glitches rejected, held press gives one step
    sw_run = 1'b0;
    cyc(4);
    @(negedge clk);
    chk("stop_st", 32'(run_state), 0);
    repeat (3) begin
      btn_step = 1'b1;
      cyc(1);
      btn_step = 1'b0;
      cyc(2);
    end
    cyc(4);
    @(negedge clk);
    chk("glitch_st", 32'(run_state), 0);
    chk("glitch_cnt", 32'(en_cnt), 5);
    @(posedge sclk);
    @(posedge clk);
    #1 btn_step = 1'b1;
    cyc(6);
    btn_step = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("step_st", 32'(run_state), 2);
    n0 = npulse;
    wait_pulse("step_tmo");
    chk("step_cnt", 32'(en_cnt), 6);
    chk("step_done", 32'(run_state), 0);
    cyc(40);
    @(negedge clk);
    chk("step_once", 32'(npulse - n0), 1);
    chk("step_hold", 32'(en_cnt), 6);

    // 3: halt coincident with tick
    @(negedge sclk);
    sw_run = 1'b1;
    @(posedge sclk);
    @(posedge clk);
    @(posedge clk);
    #1 halt_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("halt_en", 32'(cpu_en), 0);
    chk("halt_st", 32'(run_state), 3);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_cnt", 32'(en_cnt), 6);
    halt_in = 1'b0;
    cyc(25);
    @(negedge clk);
    chk("halt_stay", 32'(run_state), 3);
    chk("halt_nopulse", 32'(en_cnt), 6);
    sw_run = 1'b0;
    cyc(4);
    @(negedge clk);
    chk("unhalt_st", 32'(run_state), 0);
    chk("unhalt_flag", 32'(halted), 0);

    // 4: saturation over 20 ticks
    @(negedge sclk);
    n0 = npulse;
    sw_run = 1'b1;
    repeat (20) @(posedge sclk);
    cyc(4);
    @(negedge clk);
    chk("sat_cnt", 32'(en_cnt), 15);
    chk("sat_pulses", 32'(npulse - n0), 20);
    sw_run = 1'b0;
    cyc(4);

    // 5: reset mid-STEP and mid-pulse
    @(posedge sclk);
    @(posedge clk);
    #1 btn_step = 1'b1;
    cyc(6);
    btn_step = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("r5_step", 32'(run_state), 2);
    rst_n = 1'b0;
    #1;
    chk("r5_st", 32'(run_state), 0);
    chk("r5_cnt", 32'(en_cnt), 0);
    cyc(2);
    rst_n  = 1'b1;
    sw_run = 1'b1;
    wait_pulse("r5_tmo");
    chk("r5_first", 32'(en_cnt), 1);
    rst_n = 1'b0;
    #1;
    chk("r5_en", 32'(cpu_en), 0);
    chk("r5_cnt2", 32'(en_cnt), 0);
    chk("r5_st2", 32'(run_state), 0);
    sw_run = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    // 6: extra press and sw_run during STEP are ignored
    @(posedge sclk);
    @(posedge clk);
    #1 btn_step = 1'b1;
    n0 = npulse;
    cyc(6);
    btn_step = 1'b0;
    cyc(4);
    btn_step = 1'b1;
    sw_run   = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("s6_step", 32'(run_state), 2);
    chk("s6_en", 32'(cpu_en), 0);
    cyc(4);
    btn_step = 1'b0;
    wait_pulse("s6_tmo");
    chk("s6_stop", 32'(run_state), 0);
    chk("s6_cnt", 32'(en_cnt), 1);
    @(negedge clk);
    chk("s6_run", 32'(run_state), 1);
    chk("s6_w", 32'(cpu_en), 0);
    @(posedge sclk);
    cyc(4);
    @(negedge clk);
    chk("s6_cnt2", 32'(en_cnt), 2);
    chk("s6_pulses", 32'(npulse - n0), 2);

    chk("wide", 32'(nwide), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
